// File: rtl/fp16_mul_arbiter.sv
// Shares one pipelined fp16 multiplier among NUM_REQ requesters and routes each product back to its issuer.
// Define FP16_MUL_ARB_RR_EN for round-robin arbitration; the default build is fixed priority (lowest index wins).
module fp16_mul_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int MUL_LATENCY = 11
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [16*NUM_REQ-1:0]   req_a,
   input  logic [16*NUM_REQ-1:0]   req_b,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic                    hold,
   output logic [15:0]             mul_a,
   output logic [15:0]             mul_b,
   input  logic [15:0]             mul_out,
   output logic [NUM_REQ-1:0]      rsp_valid,
   output logic [15:0]             rsp_data,
   output logic                    busy
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(MUL_LATENCY + 1);

   // Handshake protocol: a transfer happens in a cycle where req_valid[i] & req_ready[i];
   // req_ready is one-hot and only ever asserted on a requester that is already valid.
   logic [NUM_REQ-1:0] grant;
   logic [IW-1:0]      grant_idx;
   logic               grant_any;

`ifdef FP16_MUL_ARB_RR_EN
   logic [IW-1:0] ptr;

   always_comb begin
      int idx;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!grant_any && req_valid[idx] && !hold && rst_n) begin
            grant_any = 1'b1;
            grant_idx = IW'(idx);
         end
      end
      if (grant_any) grant[grant_idx] = 1'b1;
   end

   // Pointer remembers the last winner; reset value makes requester 0 first in line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         ptr <= IW'(NUM_REQ - 1);
      else if (grant_any) ptr <= grant_idx;
   end
`else
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!grant_any && req_valid[k] && !hold && rst_n) begin
            grant_any = 1'b1;
            grant_idx = IW'(k);
         end
      end
      if (grant_any) grant[grant_idx] = 1'b1;
   end
`endif

   assign req_ready = grant;

   always_comb begin
      mul_a = 16'h0000;
      mul_b = 16'h0000;
      if (grant_any) begin
         mul_a = req_a[16*grant_idx +: 16];
         mul_b = req_b[16*grant_idx +: 16];
      end
   end

   // Tag pipeline mirrors the multiplier depth; only the valid bits need reset.
   logic [MUL_LATENCY-1:0] tag_v;
   logic [IW-1:0]          tag_idx [MUL_LATENCY];
   logic                   retire;
   logic [NUM_REQ-1:0]     ret_onehot;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tag_v <= '0;
      else        tag_v <= {tag_v[MUL_LATENCY-2:0], grant_any};
   end

   always_ff @(posedge clk) begin
      tag_idx[0] <= grant_idx;
      for (int s = 1; s < MUL_LATENCY; s++) tag_idx[s] <= tag_idx[s-1];
   end

   assign retire     = tag_v[MUL_LATENCY-1];
   assign ret_onehot = NUM_REQ'(1) << tag_idx[MUL_LATENCY-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= '0;
         rsp_data  <= 16'h0000;
      end else begin
         rsp_valid <= retire ? ret_onehot : '0;
         if (retire) rsp_data <= mul_out;
      end
   end

   logic [CW-1:0] count;
   logic [CW-1:0] count_next;

   always_comb begin
      count_next = count;
      case ({grant_any, retire})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // busy also spans the response cycle, so it drops the cycle after rsp_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         busy  <= 1'b0;
      end else begin
         count <= count_next;
         busy  <= (count_next != '0) | retire;
      end
   end

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Self-checking bench for fp16_mul_arbiter: a stand-in multiplier pipeline, a cycle-level model with an
// expected-response queue, and directed phases with hand-computed literal expectations.
module tb_fp16_mul_arbiter;
   localparam int NUM_REQ     = 4;
   localparam int MUL_LATENCY = 11;
   localparam int RSP_DELAY   = MUL_LATENCY + 1;

   logic                  clk;
   logic                  rst_n;
   logic [NUM_REQ-1:0]    req_valid;
   logic [16*NUM_REQ-1:0] req_a;
   logic [16*NUM_REQ-1:0] req_b;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  hold;
   logic [15:0]           mul_a;
   logic [15:0]           mul_b;
   logic [15:0]           mul_out;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [15:0]           rsp_data;
   logic                  busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   fp16_mul_arbiter #(.NUM_REQ(NUM_REQ), .MUL_LATENCY(MUL_LATENCY)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .hold(hold), .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // Stand-in multiplier: known fp16 products for the directed vectors, a scramble otherwise.
   function automatic logic [15:0] fake_mul(input logic [15:0] a, input logic [15:0] b);
      case ({a, b})
         32'h3C00_4000: return 16'h4000;
         32'h4200_3E00: return 16'h4480;
         32'h4000_4200: return 16'h4600;
         32'h7C00_0000: return 16'h7E00;
         32'h7C00_4000: return 16'h7C00;
         default:       return a ^ {b[7:0], b[15:8]};
      endcase
   endfunction

   logic [15:0] mpipe [MUL_LATENCY];
   always @(posedge clk) begin
      mpipe[0] <= fake_mul(mul_a, mul_b);
      for (int s = 1; s < MUL_LATENCY; s++) mpipe[s] <= mpipe[s-1];
   end
   assign mul_out = mpipe[MUL_LATENCY-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h cyc=%0d", name, act, exp, cyc);
      end
   endtask

   // ---------------- scoreboard / model ----------------
   // entry = {due_cycle[31:0], dest[2:0], product[15:0]}
   logic [50:0]        exp_q[$];
   logic [50:0]        front;
   logic [15:0]        last_data;
   logic [NUM_REQ-1:0] exp_ready;
   logic [15:0]        exp_ma;
   logic [15:0]        exp_mb;
   int                 m_ptr;
   int                 g_idx;
   int                 idx;
   bit                 found;

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_ready", 32'(req_ready), 32'd0);
         chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("rst_rsp_data", 32'(rsp_data), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_mul_ab", {mul_a, mul_b}, 32'd0);
         exp_q.delete();
         last_data = 16'h0000;
         m_ptr     = NUM_REQ - 1;
      end else begin
         found = 1'b0;
         g_idx = 0;
         if (!hold) begin
            for (int k = 0; k < NUM_REQ; k++) begin
`ifdef FP16_MUL_ARB_RR_EN
               idx = (m_ptr + 1 + k) % NUM_REQ;
`else
               idx = k;
`endif
               if (!found && req_valid[idx]) begin
                  found = 1'b1;
                  g_idx = idx;
               end
            end
         end
         exp_ready = found ? (NUM_REQ'(1) << g_idx) : '0;
         exp_ma    = found ? req_a[16*g_idx +: 16] : 16'h0000;
         exp_mb    = found ? req_b[16*g_idx +: 16] : 16'h0000;
         chk("m_ready", 32'(req_ready), 32'(exp_ready));
         chk("m_mul_ab", {mul_a, mul_b}, {exp_ma, exp_mb});
         chk("m_busy", 32'(busy), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0 && exp_q[0][50:19] == 32'(cyc)) begin
            front = exp_q.pop_front();
            last_data = front[15:0];
            chk("m_rsp_valid", 32'(rsp_valid), 32'(NUM_REQ'(1) << front[18:16]));
            chk("m_rsp_data", 32'(rsp_data), 32'(front[15:0]));
         end else begin
            chk("m_rsp_idle", 32'(rsp_valid), 32'd0);
            chk("m_rsp_hold", 32'(rsp_data), 32'(last_data));
         end
         if (found) begin
            exp_q.push_back({32'(cyc + RSP_DELAY), 3'(g_idx),
                             fake_mul(req_a[16*g_idx +: 16], req_b[16*g_idx +: 16])});
            m_ptr = g_idx;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input logic [15:0] a, input logic [15:0] b);
      req_valid[i]     = 1'b1;
      req_a[16*i +: 16] = a;
      req_b[16*i +: 16] = b;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step();
   endtask

   // ---------------- directed stimulus ----------------
   int n;
   int rsp_seen;

   initial begin
      rst_n     = 1'b0;
      hold      = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      step();
      req_valid = 4'b1111;
      @(negedge clk);
      chk("reset_ready_gated", 32'(req_ready), 32'd0);
      step();
      req_valid = '0;
      step();
      rst_n = 1'b1;
      step();

      // single op from requester 1
      drive(1, 16'h3C00, 16'h4000);
      n = cyc;
      @(negedge clk);
      chk("single_grant", 32'(req_ready), 32'h2);
      chk("single_busy_pre", 32'(busy), 32'd0);
      step();
      req_valid = '0;
      @(negedge clk);
      chk("single_busy_rise", 32'(busy), 32'd1);
      wait_until(n + 12);
      @(negedge clk);
      chk("single_rsp_valid", 32'(rsp_valid), 32'h2);
      chk("single_rsp_data", 32'(rsp_data), 32'h4000);
      chk("single_busy_last", 32'(busy), 32'd1);
      step();
      @(negedge clk);
      chk("single_busy_fall", 32'(busy), 32'd0);
      chk("single_rsp_drop", 32'(rsp_valid), 32'd0);
      chk("single_data_hold", 32'(rsp_data), 32'h4000);

      // back-to-back from requester 0
      step();
      drive(0, 16'h4200, 16'h3E00);
      n = cyc;
      step();
      drive(0, 16'h4000, 16'h4200);
      step();
      req_valid = '0;
      wait_until(n + 12);
      @(negedge clk);
      chk("b2b_first_valid", 32'(rsp_valid), 32'h1);
      chk("b2b_first_data", 32'(rsp_data), 32'h4480);
      step();
      @(negedge clk);
      chk("b2b_second_valid", 32'(rsp_valid), 32'h1);
      chk("b2b_second_data", 32'(rsp_data), 32'h4600);

      // specials, requester 2 then 3
      step();
      drive(2, 16'h7C00, 16'h4000);
      n = cyc;
      step();
      req_valid = '0;
      drive(3, 16'h7C00, 16'h0000);
      step();
      req_valid = '0;
      wait_until(n + 12);
      @(negedge clk);
      chk("spec_inf_valid", 32'(rsp_valid), 32'h4);
      chk("spec_inf_data", 32'(rsp_data), 32'h7C00);
      step();
      @(negedge clk);
      chk("spec_nan_valid", 32'(rsp_valid), 32'h8);
      chk("spec_nan_data", 32'(rsp_data), 32'h7E00);

      // contention: all requesters valid for 8 cycles
      step();
      n = cyc;
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < NUM_REQ; i++)
            drive(i, {4'(i + 1), 4'(k), 8'h11}, 16'h2233);
         @(negedge clk);
`ifdef FP16_MUL_ARB_RR_EN
         chk("cont_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
`else
         chk("cont_grant", 32'(req_ready), 32'h1);
`endif
         step();
      end
      req_valid = '0;
      wait_until(n + 12);
      @(negedge clk);
      chk("cont_first_rsp", 32'(rsp_valid), 32'h1);
      step();
      wait_until(n + 24);

      // hold with requester 2 waiting
      drive(1, 16'h1234, 16'h5678);
      step();
      req_valid = '0;
      hold = 1'b1;
      drive(2, 16'h0F0F, 16'h3C3C);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("hold_ready", 32'(req_ready), 32'd0);
         chk("hold_busy", 32'(busy), 32'd1);
         step();
      end
      hold = 1'b0;
      @(negedge clk);
      chk("hold_release_grant", 32'(req_ready), 32'h4);
      step();
      req_valid = '0;
      repeat (16) step();

      // reset mid-flight
      for (int k = 0; k < 5; k++) begin
         drive(0, 16'h0A00 + 16'(k), 16'h0B00);
         step();
      end
      req_valid = '0;
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      step();
      rst_n = 1'b1;
      rsp_seen = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (rsp_valid != '0) rsp_seen++;
         step();
      end
      chk("midrst_dropped", 32'(rsp_seen), 32'd0);
      drive(3, 16'h3C00, 16'h4000);
      n = cyc;
      step();
      req_valid = '0;
      wait_until(n + 12);
      @(negedge clk);
      chk("post_rst_valid", 32'(rsp_valid), 32'h8);
      chk("post_rst_data", 32'(rsp_data), 32'h4000);
      repeat (4) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
